// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer with a branch-target LUT.
// Optional feature: define RELATIVE_BRANCH_EN to make branch targets PC-relative
// (ProgCtr + LUT entry, modulo 2**PC_W). Left undefined, branches are absolute.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for Start after reset; PC parked at 0
// S_RUN  | fetching: PC increments, holds on stall, jumps on branch
// S_DONE | halt seen; PC frozen until Start restarts from 0
module fetch_ctrl #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Halt,
  input  logic              Stall,
  input  logic              Branch,
  input  logic [LUT_AW-1:0] TgtIdx,
  input  logic              LutWe,
  input  logic [LUT_AW-1:0] LutAddr,
  input  logic [PC_W-1:0]   LutData,
  output logic [PC_W-1:0]   ProgCtr,
  output logic              Running,
  output logic              Done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            running_q, running_d;
  logic            done_q, done_d;

  // Not reset: entries are only meaningful after software writes them.
  logic [PC_W-1:0] lut_mem [0:(2**LUT_AW)-1];
  logic [PC_W-1:0] lut_rd;
  logic [PC_W-1:0] target;

  // Read is combinational from current contents, so a same-cycle write
  // to the branch index cannot affect this cycle's target.
  assign lut_rd = lut_mem[TgtIdx];

`ifdef RELATIVE_BRANCH_EN
  assign target = pc_q + lut_rd;
`else
  assign target = lut_rd;
`endif

  // Branch-target table write port, usable in every state.
  always_ff @(posedge Clk) begin
    if (LutWe) begin
      lut_mem[LutAddr] <= LutData;
    end
  end

  // Next-state and next-PC selection; RUN priority is halt, stall, branch, increment.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      S_RUN: begin
        if (Halt) begin
          state_d = S_DONE;
        end else if (Stall) begin
          pc_d = pc_q;
        end else if (Branch) begin
          pc_d = target;
        end else begin
          pc_d = pc_q + PC_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
      end
    endcase
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  // State, PC and status flags; reset overrides every other input.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign ProgCtr = pc_q;
  assign Running = running_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed-vector bench for fetch_ctrl (PC_W=10, LUT_AW=5).
module tb_fetch_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, Start, Halt, Stall, Branch, LutWe;
  logic [4:0] TgtIdx, LutAddr;
  logic [9:0] LutData;
  logic [9:0] ProgCtr;
  logic       Running, Done;

  int checks = 0;
  int errors = 0;
  logic [9:0] p_now;
  logic [9:0] e5;

  fetch_ctrl #(.PC_W(10), .LUT_AW(5)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
    .Branch(Branch), .TgtIdx(TgtIdx), .LutWe(LutWe), .LutAddr(LutAddr),
    .LutData(LutData), .ProgCtr(ProgCtr), .Running(Running), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected branch target for a given PC and LUT entry, per build mode.
  function automatic logic [9:0] tgt(input logic [9:0] pc, input logic [9:0] entry);
`ifdef RELATIVE_BRANCH_EN
    return pc + entry;
`else
    return entry;
`endif
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic lut_wr(input logic [4:0] a, input logic [9:0] d);
    LutWe = 1'b1; LutAddr = a; LutData = d;
    tick();
    LutWe = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Start = 0; Halt = 0; Stall = 0; Branch = 0;
    LutWe = 0; TgtIdx = '0; LutAddr = '0; LutData = '0;
    tick(); tick();
    chk("rst_pc", ProgCtr, 0);
    chk("rst_running", Running, 0);
    chk("rst_done", Done, 0);
    Reset = 1'b0;

    lut_wr(5'd3, 10'h040);
    lut_wr(5'd4, 10'h3FE);
    lut_wr(5'd2, 10'h100);
    chk("idle_hold_pc", ProgCtr, 0);
    chk("idle_running", Running, 0);

    // Start then five plain RUN cycles
    Start = 1'b1; tick(); Start = 1'b0;
    chk("start_pc", ProgCtr, 0);
    chk("start_running", Running, 1);
    chk("start_done", Done, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("inc_pc", ProgCtr, i);
    end
    tick(); tick();
    chk("pc7", ProgCtr, 7);

    // Branch via LUT[3] at PC=7
    Branch = 1'b1; TgtIdx = 5'd3; tick(); Branch = 1'b0;
    chk("br_lut3", ProgCtr, tgt(10'd7, 10'h040));
    p_now = tgt(10'd7, 10'h040);
    Branch = 1'b1; TgtIdx = 5'd4; tick(); Branch = 1'b0;
    chk("br_lut4", ProgCtr, tgt(p_now, 10'h3FE));

    // Restart and walk to PC=9 for stall/halt combinations
    Reset = 1'b1; tick(); Reset = 1'b0;
    Start = 1'b1; tick(); Start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("pc9", ProgCtr, 9);
    Stall = 1'b1; Branch = 1'b1; TgtIdx = 5'd3; tick();
    chk("stall_br_hold", ProgCtr, 9);
    chk("stall_br_running", Running, 1);
    Stall = 1'b0; Branch = 1'b0; tick();
    chk("after_stall_inc", ProgCtr, 10);
    Halt = 1'b1; Branch = 1'b1; tick(); Halt = 1'b0; Branch = 1'b0;
    chk("halt_br_pc", ProgCtr, 10);
    chk("halt_done", Done, 1);
    chk("halt_running", Running, 0);
    tick();
    chk("done_hold_pc", ProgCtr, 10);
    chk("done_hold_flag", Done, 1);

    // Restart from DONE
    Start = 1'b1; tick(); Start = 1'b0;
    chk("restart_pc", ProgCtr, 0);
    chk("restart_done", Done, 0);
    chk("restart_running", Running, 1);

    // Same-cycle write and branch through index 2 uses the old entry
    LutWe = 1'b1; LutAddr = 5'd2; LutData = 10'h200;
    Branch = 1'b1; TgtIdx = 5'd2; tick();
    LutWe = 1'b0; Branch = 1'b0;
    chk("wr_rd_old", ProgCtr, tgt(10'd0, 10'h100));
    tick();
    p_now = tgt(10'd0, 10'h100) + 10'd1;
    chk("after_old_inc", ProgCtr, p_now);
    Branch = 1'b1; TgtIdx = 5'd2; tick(); Branch = 1'b0;
    chk("br_new_entry", ProgCtr, tgt(p_now, 10'h200));
    p_now = tgt(p_now, 10'h200) + 10'd1;

    // Preload PC to all-ones and check wrap
`ifdef RELATIVE_BRANCH_EN
    e5 = 10'h3FF - p_now;
`else
    e5 = 10'h3FF;
`endif
    lut_wr(5'd5, e5);
    chk("pc_during_wr", ProgCtr, p_now);
    Branch = 1'b1; TgtIdx = 5'd5; tick(); Branch = 1'b0;
    chk("preload_3ff", ProgCtr, 10'h3FF);
    tick();
    chk("wrap_pc", ProgCtr, 0);
    chk("wrap_running", Running, 1);

    // Start while running is ignored
    Start = 1'b1; tick(); Start = 1'b0;
    chk("start_in_run", ProgCtr, 1);
    for (int i = 0; i < 17; i++) tick();
    chk("pc12", ProgCtr, 10'h012);

    // Reset mid-RUN overrides a branch
    Reset = 1'b1; Branch = 1'b1; TgtIdx = 5'd3; tick();
    Reset = 1'b0; Branch = 1'b0;
    chk("midrst_pc", ProgCtr, 0);
    chk("midrst_running", Running, 0);
    chk("midrst_done", Done, 0);
    tick();
    chk("midrst_idle_pc", ProgCtr, 0);
    chk("midrst_idle_run", Running, 0);

    // LUT retained across reset
    Start = 1'b1; tick(); Start = 1'b0;
    Branch = 1'b1; TgtIdx = 5'd3; tick(); Branch = 1'b0;
    chk("lut_retained", ProgCtr, tgt(10'd0, 10'h040));

    // Halt with stall still halts
    Halt = 1'b1; Stall = 1'b1; tick(); Halt = 1'b0; Stall = 1'b0;
    chk("halt_stall_done", Done, 1);
    chk("halt_stall_pc", ProgCtr, tgt(10'd0, 10'h040));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PC_W, default 10, program counter width in bits.
REQ-002 Parameter LUT_AW, default 5, branch-target LUT address width (2**LUT_AW entries, each PC_W bits).
REQ-003 Clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  begin program execution; sampled only in IDLE or DONE.
REQ-006 Halt  input  1  current instruction is halt; sampled only in RUN.
REQ-007 Stall  input  1  hold PC for this cycle; sampled only in RUN.
REQ-008 Branch  input  1  branch-taken strobe from ALU; sampled only in RUN.
REQ-009 TgtIdx  input  LUT_AW  LUT index selecting branch target.
REQ-010 LutWe  input  1  LUT write enable.
REQ-011 LutAddr  input  LUT_AW  LUT write address.
REQ-012 LutData  input  PC_W  LUT write data.
REQ-013 ProgCtr  output  PC_W  registered address of instruction to fetch.
REQ-014 Running  output  1  registered; high while in RUN.
REQ-015 Done  output  1  registered; high while in DONE.

Function
REQ-016 FSM states IDLE, RUN, DONE; transitions occur only on rising Clk.
REQ-017 IDLE: Start=1 -> RUN, ProgCtr<=0; else hold.
REQ-018 RUN priority, highest first: Halt -> DONE, ProgCtr held; Stall -> ProgCtr held; Branch -> ProgCtr<=target; else ProgCtr<=ProgCtr+1.
REQ-019 Halt and Stall together -> DONE; Stall and Branch together -> hold, branch discarded (upstream SHALL re-present it).
REQ-020 Start in RUN is ignored.
REQ-021 DONE: Done=1, ProgCtr held; Start=1 -> RUN, ProgCtr<=0, Done<=0 on same edge.
REQ-022 Increment is modulo 2**PC_W: ProgCtr=all-ones +1 -> 0, no flag.
REQ-023 Branch-to-fetch latency: one cycle; ProgCtr shows target on the edge after Branch is sampled high.
REQ-024 LUT write is synchronous and allowed in any state; a same-cycle write to the index being read for a branch SHALL supply the old entry.
REQ-025 Running and Done are mutually exclusive; both are 0 in IDLE.

Reset
REQ-026 Reset=1 at a rising edge -> IDLE, ProgCtr=0, Running=0, Done=0, overriding all other inputs, including mid-RUN.
REQ-027 LUT contents are not cleared by Reset; entries are undefined until written.

Configuration
REQ-028 Macro RELATIVE_BRANCH_EN defined: target = ProgCtr + LUT[TgtIdx], with the entry treated as two's-complement PC_W bits and the sum taken modulo 2**PC_W.
REQ-029 Macro RELATIVE_BRANCH_EN undefined: target = LUT[TgtIdx] (absolute); all other behaviour is identical.

Verification
REQ-030 Reset, Start pulse, 5 idle RUN cycles -> ProgCtr 0,1,2,3,4,5; Running=1; Done=0.
REQ-031 LUT[3]=0x040 written, Branch=1 with TgtIdx=3 at PC=7 -> next ProgCtr=0x040 (absolute) or 0x047 (RELATIVE_BRANCH_EN); LUT[3]=0x3FE relative at PC=7 -> 0x005.
REQ-032 Stall=1 and Branch=1 at PC=9 -> PC stays 9; Halt=1 and Branch=1 -> DONE, PC held, Done=1.
REQ-033 PC preloaded to 0x3FF via absolute branch, one idle cycle -> ProgCtr=0x000, still RUN.
REQ-034 Reset asserted mid-RUN at PC=0x12 with Branch=1 -> next edge IDLE, ProgCtr=0, Running=0; LUT entries retained.
REQ-035 In DONE, Start=1 -> RUN, ProgCtr=0, Done=0; LUT write to index 2 same cycle as branch via index 2 -> old target used.
